// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator and pixel output stage
//
// Purpose: free-running h/v raster counters drive registered sync, data-enable,
// position and colour outputs. Pixels are requested from an upstream FIFO
// REQ_LEAD cycles before they are displayed, or replaced by 8 colour bars when
// test mode is latched at the start of a frame.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   din, din_valid      incoming pixel {blue,green,red} and its qualifier
//   test_mode           colour-bar select, takes effect at the next frame
//   data_req            one request per active pixel, REQ_LEAD cycles ahead
//   frame_sync          FRAME_SYNC_CYCLES pulse at the start of every frame
//   vga_hsync/vsync/de  raster timing to the DAC
//   vga_red/green/blue  colour fields
//   x_pos, y_pos        active pixel coordinates (0 outside active video)
//   underflow           sticky: a due pixel arrived without din_valid
module vga_timing_gen #(
  parameter int H_ACTIVE          = 1024,
  parameter int H_FP              = 24,
  parameter int H_SYNC            = 136,
  parameter int H_BP              = 160,
  parameter int V_ACTIVE          = 768,
  parameter int V_FP              = 3,
  parameter int V_SYNC            = 6,
  parameter int V_BP              = 29,
  parameter int HS_POL            = 0,
  parameter int VS_POL            = 0,
  parameter int R_W               = 5,
  parameter int G_W               = 6,
  parameter int B_W               = 5,
  parameter int REQ_LEAD          = 1,
  parameter int FRAME_SYNC_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R_W+G_W+B_W-1:0] din,
  input  logic                   din_valid,
  input  logic                   test_mode,
  output logic                   data_req,
  output logic                   frame_sync,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_de,
  output logic [R_W-1:0]         vga_red,
  output logic [G_W-1:0]         vga_green,
  output logic [B_W-1:0]         vga_blue,
  output logic [11:0]            x_pos,
  output logic [11:0]            y_pos,
  output logic                   underflow
);

  localparam int PIX_W   = R_W + G_W + B_W;
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // 13-bit constants so that end-of-range values equal to 4096 still compare correctly
  localparam logic [12:0] H_ACT_START = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_ACT_END   = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] H_LAST      = 13'(H_TOTAL - 1);
  localparam logic [12:0] H_SYNC_END  = 13'(H_SYNC);
  localparam logic [12:0] V_ACT_START = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_ACT_END   = 13'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [12:0] V_LAST      = 13'(V_TOTAL - 1);
  localparam logic [12:0] V_SYNC_END  = 13'(V_SYNC);
  localparam logic [12:0] FS_END      = 13'(FRAME_SYNC_CYCLES);
  localparam logic [12:0] LEAD        = 13'(REQ_LEAD);
  localparam logic [12:0] BAR_W       = 13'(H_ACTIVE / 8);
  localparam logic [11:0] X_ORIGIN    = 12'(H_SYNC + H_BP);
  localparam logic [11:0] Y_ORIGIN    = 12'(V_SYNC + V_BP);
  localparam logic        HS_ACT      = (HS_POL != 0);
  localparam logic        VS_ACT      = (VS_POL != 0);

  logic [11:0]      h_cnt_q, h_cnt_d;
  logic [11:0]      v_cnt_q, v_cnt_d;
  logic             tm_q, tm_d;
  logic             data_req_q, data_req_d;
  logic             frame_sync_q, frame_sync_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [11:0]      x_q, x_d;
  logic [11:0]      y_q, y_d;
  logic             underflow_q, underflow_d;

  logic [12:0] h_ext, v_ext, h_req;
  logic        h_last, v_last, h_act, v_act, req_act;
  logic [11:0] x_off, y_off;
  logic [2:0]  bar_idx;

  always_comb begin
    h_ext   = {1'b0, h_cnt_q};
    v_ext   = {1'b0, v_cnt_q};
    h_req   = h_ext + LEAD;
    h_last  = (h_ext == H_LAST);
    v_last  = (v_ext == V_LAST);

    h_cnt_d = h_last ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
    end

    // Test mode only changes at the frame origin so a frame is never mixed
    tm_d = (h_cnt_q == 12'd0 && v_cnt_q == 12'd0) ? test_mode : tm_q;

    h_act   = (h_ext >= H_ACT_START) && (h_ext < H_ACT_END);
    v_act   = (v_ext >= V_ACT_START) && (v_ext < V_ACT_END);
    // The lead is bounded by sync+back porch, so h_req never wraps into the next line
    req_act = (h_req >= H_ACT_START) && (h_req < H_ACT_END);

    de_d         = h_act && v_act;
    data_req_d   = req_act && v_act && !tm_q;
    hsync_d      = (h_ext < H_SYNC_END) ? HS_ACT : ~HS_ACT;
    vsync_d      = (v_ext < V_SYNC_END) ? VS_ACT : ~VS_ACT;
    frame_sync_d = (v_ext == 13'd0) && (h_ext < FS_END);

    x_off = h_cnt_q - X_ORIGIN;
    y_off = v_cnt_q - Y_ORIGIN;
    x_d   = de_d ? x_off : 12'd0;
    y_d   = de_d ? y_off : 12'd0;

    // Bar index by threshold compare instead of a divider
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, x_off} >= 13'(i) * BAR_W) begin
        bar_idx = 3'(i);
      end
    end

    pix_d       = '0;
    underflow_d = underflow_q;
    if (de_d) begin
      if (tm_q) begin
        // white, yellow, cyan, green, magenta, red, blue, black
        pix_d = {{B_W{~bar_idx[0]}}, {G_W{~bar_idx[2]}}, {R_W{~bar_idx[1]}}};
      end else if (din_valid) begin
        pix_d = din;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      tm_q         <= 1'b0;
      data_req_q   <= 1'b0;
      frame_sync_q <= 1'b0;
      hsync_q      <= ~HS_ACT;
      vsync_q      <= ~VS_ACT;
      de_q         <= 1'b0;
      pix_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      underflow_q  <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      tm_q         <= tm_d;
      data_req_q   <= data_req_d;
      frame_sync_q <= frame_sync_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      pix_q        <= pix_d;
      x_q          <= x_d;
      y_q          <= y_d;
      underflow_q  <= underflow_d;
    end
  end

  assign data_req   = data_req_q;
  assign frame_sync = frame_sync_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign vga_de     = de_q;
  assign vga_red    = pix_q[R_W-1:0];
  assign vga_green  = pix_q[R_W +: G_W];
  assign vga_blue   = pix_q[R_W+G_W +: B_W];
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on a 15x8 raster
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        test_mode = 1'b0;
  logic [15:0] din_a, din_b;
  logic        valid_a, valid_b;

  logic        data_req_a, frame_sync_a, hsync_a, vsync_a, de_a, underflow_a;
  logic [4:0]  red_a, blue_a;
  logic [5:0]  green_a;
  logic [11:0] x_pos_a, y_pos_a;
  logic        data_req_b, frame_sync_b, hsync_b, vsync_b, de_b, underflow_b;
  logic [4:0]  red_b, blue_b;
  logic [5:0]  green_b;
  logic [11:0] x_pos_b, y_pos_b;
  logic [15:0] rgb_a, rgb_b;

  assign rgb_a = {blue_a, green_a, red_a};
  assign rgb_b = {blue_b, green_b, red_b};

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .REQ_LEAD(1)
  ) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .test_mode(test_mode),
    .data_req(data_req_a), .frame_sync(frame_sync_a), .vga_hsync(hsync_a),
    .vga_vsync(vsync_a), .vga_de(de_a), .vga_red(red_a), .vga_green(green_a),
    .vga_blue(blue_a), .x_pos(x_pos_a), .y_pos(y_pos_a), .underflow(underflow_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .REQ_LEAD(3)
  ) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .test_mode(test_mode),
    .data_req(data_req_b), .frame_sync(frame_sync_b), .vga_hsync(hsync_b),
    .vga_vsync(vsync_b), .vga_de(de_b), .vga_red(red_b), .vga_green(green_b),
    .vga_blue(blue_b), .x_pos(x_pos_b), .y_pos(y_pos_b), .underflow(underflow_b)
  );

  int checks = 0;
  int failures = 0;

  // Bench raster model: tb_p is the position shown on the outputs this cycle
  int          tb_p = 119;
  logic        tb_tm = 1'b0;
  int          m_h, m_v, m_x, m_y;
  logic        m_de, m_req_a, m_req_b, m_fs;
  logic [15:0] exp_a, exp_b;

  logic        drop_en = 1'b0;
  logic        idle_valid = 1'b1;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  logic [15:0] cnt_a, cnt_b;
  logic        h1, h2, due_b;

  // Source A: lead 1, pixel presented in the same cycle as its request
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete(); cnt_a = 16'd0; din_a = '1; valid_a = 1'b1;
    end else if (data_req_a) begin
      din_a = cnt_a;
      if (drop_en && tb_p == 84) begin
        valid_a = 1'b0; q_a.push_back(16'h0000);
      end else begin
        valid_a = 1'b1; q_a.push_back(cnt_a);
      end
      cnt_a = cnt_a + 16'd1;
    end else begin
      din_a = '1; valid_a = idle_valid;
    end
  end

  // Source B: lead 3, pixel presented two cycles after its request
  always @(negedge clk) begin
    if (rst) begin
      q_b.delete(); cnt_b = 16'd0; h1 = 1'b0; h2 = 1'b0; din_b = '1; valid_b = 1'b1;
    end else begin
      due_b = h2; h2 = h1; h1 = data_req_b;
      if (due_b) begin
        din_b = cnt_b; valid_b = 1'b1; q_b.push_back(cnt_b); cnt_b = cnt_b + 16'd1;
      end else begin
        din_b = '1; valid_b = idle_valid;
      end
    end
  end

  function automatic logic [15:0] bar_pix(input int x);
    logic [2:0] c; // {r,g,b}
    case (x)
      0: c = 3'b111; 1: c = 3'b110; 2: c = 3'b011; 3: c = 3'b010;
      4: c = 3'b101; 5: c = 3'b100; 6: c = 3'b001; default: c = 3'b000;
    endcase
    return {{5{c[0]}}, {6{c[1]}}, {5{c[2]}}};
  endfunction

  task automatic step();
    @(posedge clk); #1;
    tb_p = (tb_p == 119) ? 0 : tb_p + 1;
    if (tb_p == 0) tb_tm = test_mode;
    m_h = tb_p % 15;
    m_v = tb_p / 15;
    m_de = (m_h >= 5 && m_h < 13 && m_v >= 3 && m_v < 7);
    m_req_a = (m_h >= 4 && m_h < 12 && m_v >= 3 && m_v < 7 && !tb_tm);
    m_req_b = (m_h >= 2 && m_h < 10 && m_v >= 3 && m_v < 7 && !tb_tm);
    m_fs = (tb_p < 4);
    m_x = m_de ? m_h - 5 : 0;
    m_y = m_de ? m_v - 3 : 0;
    exp_a = 16'h0000;
    exp_b = 16'h0000;
    if (m_de) begin
      if (tb_tm) begin
        exp_a = bar_pix(m_x); exp_b = bar_pix(m_x);
      end else begin
        exp_a = 16'hBAD0; exp_b = 16'hBAD0;
        if (q_a.size() > 0) exp_a = q_a.pop_front();
        if (q_b.size() > 0) exp_b = q_b.pop_front();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; test_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({data_req_a, frame_sync_a, de_a, underflow_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl_a got=%b exp=0000", {data_req_a, frame_sync_a, de_a, underflow_a}); end
    checks++; if ({hsync_a, vsync_a} !== 2'b11) begin
      failures++; $display("FAIL reset_sync_a got=%b exp=11", {hsync_a, vsync_a}); end
    checks++; if ({hsync_b, vsync_b} !== 2'b00) begin
      failures++; $display("FAIL reset_sync_b got=%b exp=00", {hsync_b, vsync_b}); end
    checks++; if ({rgb_a, x_pos_a, y_pos_a} !== 40'd0) begin
      failures++; $display("FAIL reset_pix_a rgb=%h x=%0d y=%0d exp=0", rgb_a, x_pos_a, y_pos_a); end
    checks++; if ({data_req_b, frame_sync_b, de_b, underflow_b} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl_b got=%b exp=0000", {data_req_b, frame_sync_b, de_b, underflow_b}); end
    rst = 1'b0; tb_p = 119; tb_tm = 1'b0;
  endtask

  task automatic test_sync_timing();
    int hs_lo = 0, vs_lo = 0, de_n = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (hsync_a !== (m_h >= 3)) begin
        failures++; $display("FAIL hsync_a p=%0d got=%b exp=%b", tb_p, hsync_a, m_h >= 3); end
      checks++; if (hsync_b !== (m_h < 3)) begin
        failures++; $display("FAIL hsync_b p=%0d got=%b exp=%b", tb_p, hsync_b, m_h < 3); end
      checks++; if (vsync_a !== (m_v >= 2)) begin
        failures++; $display("FAIL vsync_a p=%0d got=%b exp=%b", tb_p, vsync_a, m_v >= 2); end
      checks++; if (vsync_b !== (m_v < 2)) begin
        failures++; $display("FAIL vsync_b p=%0d got=%b exp=%b", tb_p, vsync_b, m_v < 2); end
      checks++; if ({de_a, de_b} !== {m_de, m_de}) begin
        failures++; $display("FAIL de p=%0d got=%b%b exp=%b", tb_p, de_a, de_b, m_de); end
      checks++; if ({frame_sync_a, frame_sync_b} !== {m_fs, m_fs}) begin
        failures++; $display("FAIL frame_sync p=%0d got=%b%b exp=%b", tb_p, frame_sync_a, frame_sync_b, m_fs); end
      checks++; if (x_pos_a !== 12'(m_x) || y_pos_a !== 12'(m_y)) begin
        failures++; $display("FAIL xy_a p=%0d got=%0d,%0d exp=%0d,%0d", tb_p, x_pos_a, y_pos_a, m_x, m_y); end
      if (!hsync_a) hs_lo++;
      if (!vsync_a) vs_lo++;
      if (de_a) de_n++;
    end
    checks++; if (hs_lo !== 24) begin failures++; $display("FAIL hsync_low_count got=%0d exp=24", hs_lo); end
    checks++; if (vs_lo !== 30) begin failures++; $display("FAIL vsync_low_count got=%0d exp=30", vs_lo); end
    checks++; if (de_n !== 32) begin failures++; $display("FAIL de_count got=%0d exp=32", de_n); end
  endtask

  task automatic test_data_req();
    int n_a = 0, n_b = 0, r_a = -1, r_b = -1, r_de = -1;
    logic pa = 1'b0, pb = 1'b0, pd = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (data_req_a !== m_req_a) begin
        failures++; $display("FAIL data_req_a p=%0d got=%b exp=%b", tb_p, data_req_a, m_req_a); end
      checks++; if (data_req_b !== m_req_b) begin
        failures++; $display("FAIL data_req_b p=%0d got=%b exp=%b", tb_p, data_req_b, m_req_b); end
      if (data_req_a) n_a++;
      if (data_req_b) n_b++;
      if (data_req_a && !pa && r_a < 0) r_a = tb_p;
      if (data_req_b && !pb && r_b < 0) r_b = tb_p;
      if (de_a && !pd && r_de < 0) r_de = tb_p;
      pa = data_req_a; pb = data_req_b; pd = de_a;
    end
    checks++; if (n_a !== 32 || n_b !== 32) begin
      failures++; $display("FAIL req_count got=%0d,%0d exp=32,32", n_a, n_b); end
    checks++; if (r_de - r_a !== 1) begin
      failures++; $display("FAIL lead_a got=%0d exp=1", r_de - r_a); end
    checks++; if (r_de - r_b !== 3) begin
      failures++; $display("FAIL lead_b got=%0d exp=3", r_de - r_b); end
  endtask

  task automatic test_pixel_order();
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (rgb_a !== exp_a) begin
        failures++; $display("FAIL rgb_a p=%0d got=%h exp=%h", tb_p, rgb_a, exp_a); end
      checks++; if (rgb_b !== exp_b) begin
        failures++; $display("FAIL rgb_b p=%0d got=%h exp=%h", tb_p, rgb_b, exp_b); end
    end
  endtask

  task automatic test_underflow();
    drop_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (rgb_a !== exp_a) begin
        failures++; $display("FAIL uf_rgb_a p=%0d got=%h exp=%h", tb_p, rgb_a, exp_a); end
      if (tb_p == 84) begin
        checks++; if (underflow_a !== 1'b0) begin
          failures++; $display("FAIL uf_before got=%b exp=0", underflow_a); end
      end
      if (tb_p == 85) begin
        checks++; if (rgb_a !== 16'h0000 || x_pos_a !== 12'd5 || y_pos_a !== 12'd2) begin
          failures++; $display("FAIL uf_pixel rgb=%h x=%0d y=%0d exp=0,5,2", rgb_a, x_pos_a, y_pos_a); end
      end
      if (tb_p == 86) begin
        checks++; if (underflow_a !== 1'b1) begin
          failures++; $display("FAIL uf_set got=%b exp=1", underflow_a); end
      end
    end
    drop_en = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (rgb_a !== exp_a) begin
        failures++; $display("FAIL uf2_rgb_a p=%0d got=%h exp=%h", tb_p, rgb_a, exp_a); end
      if (tb_p == 0 || tb_p == 119) begin
        checks++; if (underflow_a !== 1'b1) begin
          failures++; $display("FAIL uf_sticky p=%0d got=%b exp=1", tb_p, underflow_a); end
      end
    end
    checks++; if (underflow_b !== 1'b0) begin
      failures++; $display("FAIL uf_b got=%b exp=0", underflow_b); end
  endtask

  task automatic test_test_mode();
    for (int i = 0; i < 120; i++) begin
      step();
      if (tb_p == 59) test_mode = 1'b1;
      checks++; if (data_req_a !== m_req_a || rgb_a !== exp_a) begin
        failures++; $display("FAIL tm_pending p=%0d req=%b rgb=%h exp=%b,%h", tb_p, data_req_a, rgb_a, m_req_a, exp_a); end
    end
    for (int i = 0; i < 120; i++) begin
      step();
      if (tb_p == 0) idle_valid = 1'b0;
      if (tb_p == 60) test_mode = 1'b0;
      checks++; if (data_req_a !== 1'b0 || data_req_b !== 1'b0) begin
        failures++; $display("FAIL tm_req p=%0d got=%b%b exp=00", tb_p, data_req_a, data_req_b); end
      checks++; if (rgb_a !== exp_a || rgb_b !== exp_b) begin
        failures++; $display("FAIL tm_bars p=%0d got=%h,%h exp=%h,%h", tb_p, rgb_a, rgb_b, exp_a, exp_b); end
      if (tb_p == 50) begin
        checks++; if (rgb_a !== 16'hFFFF) begin failures++; $display("FAIL tm_white got=%h exp=ffff", rgb_a); end
      end
      if (tb_p == 57) begin
        checks++; if (rgb_a !== 16'h0000 || de_a !== 1'b1) begin
          failures++; $display("FAIL tm_black got=%h de=%b exp=0000,1", rgb_a, de_a); end
      end
    end
    checks++; if (underflow_b !== 1'b0) begin
      failures++; $display("FAIL tm_underflow_b got=%b exp=0", underflow_b); end
    idle_valid = 1'b1;
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (data_req_a !== m_req_a || rgb_a !== exp_a || rgb_b !== exp_b) begin
        failures++; $display("FAIL tm_exit p=%0d req=%b rgb=%h,%h exp=%b,%h,%h", tb_p, data_req_a, rgb_a, rgb_b, m_req_a, exp_a, exp_b); end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 54; i++) step();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({data_req_a, frame_sync_a, de_a, underflow_a, hsync_a, vsync_a} !== 6'b000011) begin
      failures++; $display("FAIL mid_reset_a got=%b exp=000011", {data_req_a, frame_sync_a, de_a, underflow_a, hsync_a, vsync_a}); end
    checks++; if ({rgb_a, x_pos_a, y_pos_a} !== 40'd0) begin
      failures++; $display("FAIL mid_reset_pix rgb=%h x=%0d y=%0d exp=0", rgb_a, x_pos_a, y_pos_a); end
    checks++; if ({data_req_b, de_b, hsync_b, vsync_b} !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_b got=%b exp=0000", {data_req_b, de_b, hsync_b, vsync_b}); end
    rst = 1'b0; tb_p = 119; tb_tm = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      checks++; if (frame_sync_a !== m_fs || hsync_a !== (m_h >= 3) || de_a !== m_de) begin
        failures++; $display("FAIL restart p=%0d fs=%b hs=%b de=%b", tb_p, frame_sync_a, hsync_a, de_a); end
      checks++; if (rgb_a !== exp_a) begin
        failures++; $display("FAIL restart_rgb p=%0d got=%h exp=%h", tb_p, rgb_a, exp_a); end
      if (tb_p == 51 || tb_p == 57 || tb_p == 65) begin
        checks++; if (rgb_a !== ((tb_p == 51) ? 16'd1 : (tb_p == 57) ? 16'd7 : 16'd8)) begin
          failures++; $display("FAIL restart_seq p=%0d got=%h", tb_p, rgb_a); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_data_req();
    test_pixel_order();
    test_underflow();
    test_test_mode();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator and pixel output stage. It replaces the fixed 1024x768 controller. All porch, sync and active counts are parameters, and sync polarity and colour field widths are configurable. The pixel request lead time is programmable, with a din_valid handshake, underflow detection and a built-in colour-bar test pattern. It sits between the frame-buffer read FIFO and the VGA DAC pins.

Parameters:
H_ACTIVE, 1024, active pixels per line (must be a multiple of 8)
H_FP, 24, horizontal front porch cycles
H_SYNC, 136, hsync pulse cycles
H_BP, 160, horizontal back porch cycles
V_ACTIVE, 768, active lines per frame
V_FP, 3, vertical front porch lines
V_SYNC, 6, vsync pulse lines
V_BP, 29, vertical back porch lines
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
R_W, 5, red field width
G_W, 6, green field width
B_W, 5, blue field width
REQ_LEAD, 1, cycles from data_req to matching pixel on output (1..H_SYNC+H_BP)
FRAME_SYNC_CYCLES, 4, frame_sync pulse length (1..H_SYNC)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
din  in  R_W+G_W+B_W  pixel, packed {blue,green,red}, red in LSBs
din_valid  in  1  din carries a valid pixel this cycle
test_mode  in  1  1 = colour bars, 0 = din
data_req  out  1  pixel request, one per active pixel
frame_sync  out  1  start-of-frame pulse
vga_hsync  out  1  horizontal sync
vga_vsync  out  1  vertical sync
vga_de  out  1  active-video enable
vga_red  out  R_W  red
vga_green  out  G_W  green
vga_blue  out  B_W  blue
x_pos  out  12  active pixel column
y_pos  out  12  active pixel row
underflow  out  1  sticky: pixel due but din_valid low

Behaviour:
- Constraints: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP ≤ 4096. V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP ≤ 4096.
- Counters: h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments on h_cnt wrap, and wraps from V_TOTAL-1 to 0.
- Line order: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch. Frame order is the same for vertical.
- All outputs are registered. The outputs in cycle k describe the counter position held in cycle k-1.
- First edge after rst low: outputs show position (0,0) and counters advance to (1,0).
- Reset (any cycle, including mid-frame): counters = 0, test_mode latch = 0, data_req = 0, frame_sync = 0, vga_de = 0, rgb = 0, x_pos = y_pos = 0, underflow = 0, vga_hsync = ~HS_POL, vga_vsync = ~VS_POL.
- vga_hsync = HS_POL while h_cnt < H_SYNC.
- vga_vsync = VS_POL while v_cnt < V_SYNC. It changes only on the output cycle showing h = 0.
- vga_de = 1 when both h and v are active.
- x_pos = h_cnt-(H_SYNC+H_BP) and y_pos = v_cnt-(V_SYNC+V_BP) when de = 1; both are 0 otherwise.
- data_req = 1 when h_cnt+REQ_LEAD is in the horizontal active range and v_cnt is active, with test_mode latch = 0.
- data_req is exactly H_ACTIVE contiguous cycles per active line and never crosses a line boundary. Its rising edge leads the vga_de rising edge by exactly REQ_LEAD cycles.
- din and din_valid are sampled on the edge that registers the corresponding de = 1 output, i.e. in the cycle REQ_LEAD-1 after the matching data_req cycle.
- If din_valid = 1: rgb = din.
- If din_valid = 0 while a pixel is due: rgb = 0 for that pixel, underflow is set, and it stays set until rst. Nothing is re-fetched.
- When de = 0, rgb = 0 and din/din_valid are ignored.
- test_mode is latched only when the counters are at (0,0), so it takes effect at the frame boundary.
- Latched test_mode = 1: data_req stays 0, din_valid is ignored, underflow is unaffected.
- Colour bars: 8 bars, each H_ACTIVE/8 wide. Index = x_pos/(H_ACTIVE/8). Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel field is all-ones or all-zeros.
- frame_sync = 1 for FRAME_SYNC_CYCLES cycles starting with the output cycle showing (0,0), every frame, including the first frame after reset.

Test Plan:
(Small timing: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, H_TOTAL=15, V_TOTAL=8.)
- Release rst, test_mode=0, din_valid=1 -> hsync low 3 of every 15 cycles; vsync low 30 cycles per 120; de high 8 cycles per line on lines 3..6; frame_sync high cycles 1..4 after release.
- REQ_LEAD=1 then 3, din = incrementing counter on each data_req -> data_req rises 1/3 cycles before de; x_pos 0..7 sees rgb 0..7 in order; 32 data_req and 32 de cycles per frame.
- Drop din_valid for one pixel at x=5,y=2 -> that pixel rgb=0, underflow=1 from next cycle, stays 1 across frames until rst.
- Raise test_mode mid-frame -> no change until next (0,0); then data_req=0; each bar is 1 pixel wide: white (all 1s) at x=0, black at x=7.
- Assert rst for 1 cycle mid-active line -> all outputs at reset values next cycle; timing restarts at (0,0) with a fresh frame_sync.
- HS_POL=1, VS_POL=1 -> sync pulses high with the same positions; reset levels low.
